ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Open-drain clock/data drive (oe=1 pulls line low); the device generates all bit clocks.
//  Sits beside ps2_keyboard on the same ps2_clk/ps2_data pins; tx_busy gates the receiver while sending.
// PARAMETERS
//  INHIBIT_CYCLES  5000     clk cycles ps2_clk is held low before request-to-send (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  1000000  max clk cycles from RTS to ACK edge (20 ms @ 50 MHz)
//  MAX_RETRY       2        extra attempts after a failure (used only with PS2_TX_RETRY_EN)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous active-high reset
//  tx_valid     in   1  command byte request
//  tx_data      in   8  command byte
//  tx_ready     out  1  high only in IDLE; byte accepted on tx_valid&tx_ready
//  tx_busy      out  1  high in every state except IDLE
//  tx_done      out  1  one-cycle pulse: device ACKed and both lines returned high
//  tx_err       out  1  one-cycle pulse: transfer abandoned
//  err_code     out  2  valid with tx_err: 01 timeout, 10 NACK (held until next accept)
//  ps2_clk      in   1  raw PS/2 clock line
//  ps2_data     in   1  raw PS/2 data line
//  ps2_clk_oe   out  1  1 = drive clock low
//  ps2_data_oe  out  1  1 = drive data low
// BEHAVIOUR
//  Reset: state IDLE, tx_ready=1, tx_busy/tx_done/tx_err=0, err_code=00, both oe=0, counters 0.
//   rst mid-frame releases both lines on the next cycle; no done/err pulse.
//  Line inputs pass a 3-flop synchronizer; "fall" = one-cycle pulse on synchronized ps2_clk 1->0.
//  Accept: latch tx_data; parity = ~^tx_data (odd); next cycle -> INHIBIT. tx_valid while busy ignored.
//  INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles; last cycle sets data_oe=1 -> RTS.
//  RTS: clk_oe=0, data_oe=1 (start bit 0); timeout counter starts at 0.
//  Falls 1..8: after fall k drive bit k-1 of byte (LSB first); data_oe = ~bit. State DATA, bit_idx 0..7.
//  Fall 9: drive parity (PARITY). Fall 10: data_oe=0 (stop bit 1) -> ACK.
//  ACK: on fall 11 sample synchronized ps2_data: 0 -> WAIT_IDLE; 1 -> fail NACK.
//  WAIT_IDLE: wait until synced clk and data both 1, then tx_done pulse, -> IDLE.
//  Timeout: counter increments each cycle in RTS..ACK; reaching TIMEOUT_CYCLES -> fail timeout.
//   WAIT_IDLE is also bounded by the same counter.
//  Fail: both oe=0 that cycle, tx_err pulse, err_code set, -> IDLE.
//  Simultaneous fall and timeout in the same cycle: timeout wins.
//  Counters sized $clog2(max+1); no wrap is possible before the compare fires.
//  Latency: done occurs >= INHIBIT_CYCLES+3 cycles after accept; set by device clock otherwise.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined: on fail, if retry_cnt<MAX_RETRY, increment it and re-enter INHIBIT.
//   Same byte is resent; no tx_err. tx_err is raised only on the final failure.
//   retry_cnt clears on accept.
//  Undefined: every fail raises tx_err immediately; MAX_RETRY is unused.
// STRUCTURE
//  ps2_pkg: state encoding (IDLE, INHIBIT, RTS, DATA, PARITY, ACK, WAIT_IDLE).
//   Also: err codes, odd_parity function, command constants 0xED/0xF4/0xFE/0xFF.
//  Sub-module ps2_sync_edge: 3-flop synchronizer plus falling-edge pulse, one instance each for clk and data.
//  Top of block: FSM, bit index, inhibit/timeout counters, retry counter.
// TESTING (INHIBIT_CYCLES=4, TIMEOUT_CYCLES=200; bench device model clocks 10-cycle half periods)
//  1. Send 0xED, device ACKs.
//     Expect: clk_oe high exactly 4 cycles; device samples 0,1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done 1 pulse.
//  2. Send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; send 0x01 -> parity bit 0. All ACKed.
//  3. Device holds data high on fall 11 -> tx_err with err_code=10, both oe=0, tx_ready=1 next cycle.
//  4. Device never clocks after RTS -> tx_err at 200 cycles after RTS, err_code=01, lines released.
//  5. Assert rst during DATA (after fall 4) -> next cycle both oe=0, tx_ready=1, no done/err pulse.
//     A new 0xF4 then completes normally.
//  6. PS2_TX_RETRY_EN, device NACKs twice then ACKs -> three INHIBIT phases, single tx_done, no tx_err.
//     Undefined: first NACK gives tx_err.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 host transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_ACK       = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } ps2_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_NACK    = 2'b10
    } ps2_err_e;

    localparam logic [7:0] c_cmd_set_leds = 8'hED;
    localparam logic [7:0] c_cmd_enable   = 8'hF4;
    localparam logic [7:0] c_cmd_resend   = 8'hFE;
    localparam logic [7:0] c_cmd_reset    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_sync_edge.sv
// ============================================================================
// Module      : ps2_sync_edge
// Description : 3-flop synchronizer for a raw PS/2 line with falling-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    // Reset to the idle-high level so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], line_i};
        end
    end

    assign level_o = sync_q[1];
    assign fall_o  = sync_q[2] & ~sync_q[1];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter with open-drain drive.
//               Define PS2_TX_RETRY_EN to retry failed transfers MAX_RETRY times.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    import ps2_pkg::*;

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] c_inh_last = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] c_tmo_max  = TMO_W'(TIMEOUT_CYCLES);

    ps2_state_e        state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic              par_q, par_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [1:0]        err_code_q, err_code_d;
`ifdef PS2_TX_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] c_retry_max = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0] retry_q, retry_d;
`endif

    logic w_clk_lvl, w_clk_fall;
    logic w_data_lvl, w_data_fall_unused;
    logic w_tmo_state, w_fail;
    logic [1:0] w_fail_code;

    ps2_sync_edge u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_clk),
        .level_o (w_clk_lvl),
        .fall_o  (w_clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_data),
        .level_o (w_data_lvl),
        .fall_o  (w_data_fall_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_q     <= 8'h00;
            par_q      <= 1'b0;
            bit_idx_q  <= 3'd0;
            inh_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            err_code_q <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            inh_cnt_q  <= inh_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_code_q <= err_code_d;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign w_tmo_state = (state_q == ST_RTS)    || (state_q == ST_DATA) ||
                         (state_q == ST_PARITY) || (state_q == ST_ACK)  ||
                         (state_q == ST_WAIT_IDLE);

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        par_d       = par_q;
        bit_idx_d   = bit_idx_q;
        inh_cnt_d   = inh_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_code_d  = err_code_q;
`ifdef PS2_TX_RETRY_EN
        retry_d     = retry_q;
`endif
        tx_ready    = 1'b0;
        tx_busy     = 1'b1;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = ERR_NONE;

        if (w_tmo_state) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_ready = 1'b1;
                tx_busy  = 1'b0;
                if (tx_valid) begin
                    byte_d     = tx_data;
                    par_d      = odd_parity(tx_data);
                    err_code_d = ERR_NONE;
                    inh_cnt_d  = '0;
`ifdef PS2_TX_RETRY_EN
                    retry_d    = '0;
`endif
                    state_d    = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt_q == c_inh_last) begin
                    // Pull data low while clock is still held so RTS is seen cleanly.
                    ps2_data_oe = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = ST_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            ST_RTS: begin
                ps2_data_oe = 1'b1;
                if (w_clk_fall) begin
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                ps2_data_oe = ~byte_q[bit_idx_q];
                if (w_clk_fall) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                ps2_data_oe = ~par_q;
                if (w_clk_fall) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (w_clk_fall) begin
                    if (!w_data_lvl) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_NACK;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (w_clk_lvl && w_data_lvl) begin
                    tx_done = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout overrides whatever the line did in the same cycle.
        if (w_tmo_state && (tmo_cnt_q == c_tmo_max)) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_TIMEOUT;
            tx_done     = 1'b0;
        end

        if (w_fail) begin
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < c_retry_max) begin
                retry_d   = retry_q + 1'b1;
                inh_cnt_d = '0;
                state_d   = ST_INHIBIT;
            end else begin
                tx_err     = 1'b1;
                err_code_d = w_fail_code;
                state_d    = ST_IDLE;
            end
`else
            tx_err     = 1'b1;
            err_code_d = w_fail_code;
            state_d    = ST_IDLE;
`endif
        end
    end

    assign err_code = tx_err ? w_fail_code : err_code_q;

endmodule

`default_nettype wire
